// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : memory_arbiter
//  Purpose  : Round-robin arbiter that shares one memory port between three
//             requesters (0 = instruction fetch, 1 = load/store, 2 = UART
//             loader). One transaction is outstanding at a time. The flow is
//             IDLE (arbitrate and accept), ISSUE (downstream handshake), then
//             WAIT_RESP (downstream completion).
//  Optional : MEMORY_ARBITER_WATCHDOG_EN builds a response watchdog. It aborts
//             WAIT_RESP after WATCHDOG_CYCLES cycles with a zero-data response
//             and a timeout_error pulse. Without it, WAIT_RESP waits forever.
//  Ports    :
//    clock, clear            - clock (rising edge), async active-low reset
//    chN_req_valid/ready     - per-channel request handshake (ready is
//                              combinational in the accepting IDLE cycle)
//    chN_req_write/address/write_data - per-channel request fields
//    chN_resp_valid          - one-cycle completion pulse to the owner
//    chN_resp_read_data      - read data while resp_valid, otherwise 0
//    mem_req_*               - downstream request (valid/ready handshake)
//    mem_resp_valid/read_data- downstream completion (reads and writes)
//    grant                   - owning channel, 3 when idle
//    timeout_error           - one-cycle pulse on a watchdog abort
//  Revision : 1.0  initial release
// ============================================================================
module memory_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WATCHDOG_CYCLES = 64
) (
  input  logic                     clock,
  input  logic                     clear,
  // channel 0 : instruction fetch
  input  logic                     ch0_req_valid,
  output logic                     ch0_req_ready,
  input  logic                     ch0_req_write,
  input  logic [ADDRESS_WIDTH-1:0] ch0_req_address,
  input  logic [DATA_WIDTH-1:0]    ch0_req_write_data,
  output logic                     ch0_resp_valid,
  output logic [DATA_WIDTH-1:0]    ch0_resp_read_data,
  // channel 1 : load/store
  input  logic                     ch1_req_valid,
  output logic                     ch1_req_ready,
  input  logic                     ch1_req_write,
  input  logic [ADDRESS_WIDTH-1:0] ch1_req_address,
  input  logic [DATA_WIDTH-1:0]    ch1_req_write_data,
  output logic                     ch1_resp_valid,
  output logic [DATA_WIDTH-1:0]    ch1_resp_read_data,
  // channel 2 : UART loader
  input  logic                     ch2_req_valid,
  output logic                     ch2_req_ready,
  input  logic                     ch2_req_write,
  input  logic [ADDRESS_WIDTH-1:0] ch2_req_address,
  input  logic [DATA_WIDTH-1:0]    ch2_req_write_data,
  output logic                     ch2_resp_valid,
  output logic [DATA_WIDTH-1:0]    ch2_resp_read_data,
  // downstream memory
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_write,
  output logic [ADDRESS_WIDTH-1:0] mem_req_address,
  output logic [DATA_WIDTH-1:0]    mem_req_write_data,
  input  logic                     mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_resp_read_data,
  // status
  output logic [1:0]               grant,
  output logic                     timeout_error
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  localparam logic [1:0] NO_GRANT = 2'd3;

  if (WATCHDOG_CYCLES < 1) begin : g_watchdog_param_check
    $error("memory_arbiter: WATCHDOG_CYCLES must be at least 1");
  end

  state_t                   state;
  logic [1:0]               last_grant;
  logic                     lat_write;
  logic [ADDRESS_WIDTH-1:0] lat_address;
  logic [DATA_WIDTH-1:0]    lat_write_data;
  logic [2:0]               resp_pulse;
  logic [DATA_WIDTH-1:0]    resp_data;

  // Gather the channels into indexable form.
  logic [2:0]               req_valid;
  logic [2:0]               req_write;
  logic [ADDRESS_WIDTH-1:0] req_address    [3];
  logic [DATA_WIDTH-1:0]    req_write_data [3];

  assign req_valid         = {ch2_req_valid, ch1_req_valid, ch0_req_valid};
  assign req_write         = {ch2_req_write, ch1_req_write, ch0_req_write};
  assign req_address[0]    = ch0_req_address;
  assign req_address[1]    = ch1_req_address;
  assign req_address[2]    = ch2_req_address;
  assign req_write_data[0] = ch0_req_write_data;
  assign req_write_data[1] = ch1_req_write_data;
  assign req_write_data[2] = ch2_req_write_data;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  // Round-robin search, starting one past the previous winner.
  logic [1:0] first_ch;
  logic [1:0] second_ch;
  logic [1:0] third_ch;
  logic [1:0] winner;
  logic       accept;

  always_comb begin
    first_ch  = next_ch(last_grant);
    second_ch = next_ch(first_ch);
    third_ch  = next_ch(second_ch);
    winner    = third_ch;
    if (req_valid[first_ch]) begin
      winner = first_ch;
    end else if (req_valid[second_ch]) begin
      winner = second_ch;
    end
  end

  // clear is folded in so that no ready can leak out while held in reset.
  assign accept = clear && (state == IDLE) && (|req_valid);

  assign ch0_req_ready = accept && (winner == 2'd0);
  assign ch1_req_ready = accept && (winner == 2'd1);
  assign ch2_req_ready = accept && (winner == 2'd2);

  assign mem_req_valid      = (state == ISSUE);
  assign mem_req_write      = lat_write;
  assign mem_req_address    = lat_address;
  assign mem_req_write_data = lat_write_data;

  assign ch0_resp_valid     = resp_pulse[0];
  assign ch1_resp_valid     = resp_pulse[1];
  assign ch2_resp_valid     = resp_pulse[2];
  assign ch0_resp_read_data = resp_pulse[0] ? resp_data : '0;
  assign ch1_resp_read_data = resp_pulse[1] ? resp_data : '0;
  assign ch2_resp_read_data = resp_pulse[2] ? resp_data : '0;

`ifdef MEMORY_ARBITER_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_count;
  logic            timeout_pulse;

  assign timeout_error = timeout_pulse;
`else
  assign timeout_error = 1'b0;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state          <= IDLE;
      last_grant     <= 2'd2;
      grant          <= NO_GRANT;
      lat_write      <= 1'b0;
      lat_address    <= '0;
      lat_write_data <= '0;
      resp_pulse     <= 3'b000;
      resp_data      <= '0;
`ifdef MEMORY_ARBITER_WATCHDOG_EN
      wd_count       <= '0;
      timeout_pulse  <= 1'b0;
`endif
    end else begin
      // Completion outputs are single-cycle pulses.
      resp_pulse <= 3'b000;
      resp_data  <= '0;
`ifdef MEMORY_ARBITER_WATCHDOG_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write      <= req_write[winner];
            lat_address    <= req_address[winner];
            lat_write_data <= req_write_data[winner];
            last_grant     <= winner;
            grant          <= winner;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
`ifdef MEMORY_ARBITER_WATCHDOG_EN
            wd_count <= '0;
`endif
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            resp_pulse[grant] <= 1'b1;
            // Write completions carry no data.
            resp_data <= lat_write ? '0 : mem_resp_read_data;
            grant     <= NO_GRANT;
            state     <= IDLE;
          end
`ifdef MEMORY_ARBITER_WATCHDOG_EN
          else if (wd_count == WD_LAST) begin
            resp_pulse[grant] <= 1'b1;
            timeout_pulse     <= 1'b1;
            grant             <= NO_GRANT;
            state             <= IDLE;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
`endif
        end
        default: begin
          grant <= NO_GRANT;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_arbiter
//  Purpose  : Directed, self-checking bench for memory_arbiter. Inputs change
//             1 time unit after the rising edge. Outputs are sampled 3 units
//             after the edge, before the next edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memory_arbiter;

  logic        clock = 1'b0;
  logic        clear;
  logic [2:0]  req_valid;
  logic [2:0]  req_write;
  logic [31:0] req_address    [3];
  logic [31:0] req_write_data [3];

  logic        ch0_req_ready, ch1_req_ready, ch2_req_ready;
  logic        ch0_resp_valid, ch1_resp_valid, ch2_resp_valid;
  logic [31:0] ch0_resp_read_data, ch1_resp_read_data, ch2_resp_read_data;

  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_address, mem_req_write_data;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_read_data;
  logic [1:0]  grant;
  logic        timeout_error;

  logic [2:0]  ready_v;
  logic [2:0]  resp_v;
  assign ready_v = {ch2_req_ready, ch1_req_ready, ch0_req_ready};
  assign resp_v  = {ch2_resp_valid, ch1_resp_valid, ch0_resp_valid};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  memory_arbiter #(
    .ADDRESS_WIDTH   (32),
    .DATA_WIDTH      (32),
    .WATCHDOG_CYCLES (4)
  ) dut (
    .clock              (clock),
    .clear              (clear),
    .ch0_req_valid      (req_valid[0]),
    .ch0_req_ready      (ch0_req_ready),
    .ch0_req_write      (req_write[0]),
    .ch0_req_address    (req_address[0]),
    .ch0_req_write_data (req_write_data[0]),
    .ch0_resp_valid     (ch0_resp_valid),
    .ch0_resp_read_data (ch0_resp_read_data),
    .ch1_req_valid      (req_valid[1]),
    .ch1_req_ready      (ch1_req_ready),
    .ch1_req_write      (req_write[1]),
    .ch1_req_address    (req_address[1]),
    .ch1_req_write_data (req_write_data[1]),
    .ch1_resp_valid     (ch1_resp_valid),
    .ch1_resp_read_data (ch1_resp_read_data),
    .ch2_req_valid      (req_valid[2]),
    .ch2_req_ready      (ch2_req_ready),
    .ch2_req_write      (req_write[2]),
    .ch2_req_address    (req_address[2]),
    .ch2_req_write_data (req_write_data[2]),
    .ch2_resp_valid     (ch2_resp_valid),
    .ch2_resp_read_data (ch2_resp_read_data),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_write      (mem_req_write),
    .mem_req_address    (mem_req_address),
    .mem_req_write_data (mem_req_write_data),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_read_data (mem_resp_read_data),
    .grant              (grant),
    .timeout_error      (timeout_error)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_req(input int ch, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[ch]      = v;
    req_write[ch]      = w;
    req_address[ch]    = a;
    req_write_data[ch] = d;
  endtask

  function automatic logic [31:0] rdata(input int ch);
    case (ch)
      0:       return ch0_resp_read_data;
      1:       return ch1_resp_read_data;
      default: return ch2_resp_read_data;
    endcase
  endfunction

  task automatic apply_reset();
    clear          = 1'b0;
    req_valid      = 3'b000;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    step();
    step();
    clear = 1'b1;
  endtask

  logic [2:0] oh;

  initial begin
    clear              = 1'b0;
    req_valid          = 3'b000;
    req_write          = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req_address[i]    = '0;
      req_write_data[i] = '0;
    end
    mem_req_ready      = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_read_data = '0;

    // Reset: all requests pending, yet no ready may escape.
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h30, 32'h0);
    step();
    settle();
    check_value("rst_grant", grant, 2'd3);
    check_value("rst_ready", ready_v, 3'b000);
    check_value("rst_mem_valid", mem_req_valid, 1'b0);
    check_value("rst_resp", resp_v, 3'b000);
    check_value("rst_timeout", timeout_error, 1'b0);
    check_value("rst_addr", mem_req_address, 32'h0);

    // After release, channel 0 wins first. All requests drop before the edge.
    step();
    clear = 1'b1;
    settle();
    check_value("first_winner_ch0", ready_v, 3'b001);
    req_valid = 3'b000;

    // Single read on ch1.
    step();
    set_req(1, 1'b1, 1'b0, 32'h100, 32'h0);
    mem_req_ready = 1'b1;
    settle();
    check_value("rd_ready", ready_v, 3'b010);
    check_value("rd_grant_t0", grant, 2'd3);
    step();                                   // T1
    req_valid = 3'b000;
    settle();
    check_value("rd_mem_valid", mem_req_valid, 1'b1);
    check_value("rd_mem_addr", mem_req_address, 32'h100);
    check_value("rd_mem_write", mem_req_write, 1'b0);
    check_value("rd_grant_t1", grant, 2'd1);
    check_value("rd_ready_busy", ready_v, 3'b000);
    step();                                   // T2
    mem_req_ready      = 1'b0;
    mem_resp_valid     = 1'b1;
    mem_resp_read_data = 32'hDEADBEEF;
    settle();
    check_value("rd_grant_t2", grant, 2'd1);
    check_value("rd_mem_valid_t2", mem_req_valid, 1'b0);
    step();                                   // T3
    mem_resp_valid = 1'b0;
    settle();
    check_value("rd_resp", resp_v, 3'b010);
    check_value("rd_data", ch1_resp_read_data, 32'hDEADBEEF);
    check_value("rd_grant_t3", grant, 2'd3);
    step();
    settle();
    check_value("rd_resp_end", resp_v, 3'b000);
    check_value("rd_data_end", ch1_resp_read_data, 32'h0);

    // Round robin with all three channels requesting continuously.
    apply_reset();
    set_req(0, 1'b1, 1'b0, 32'h1000, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h2000, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h3000, 32'h0);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      oh = 3'b001 << (k % 3);
      settle();
      check_value("rr_ready", ready_v, oh);
      step();
      settle();
      check_value("rr_addr", mem_req_address, 64'(32'h1000 * ((k % 3) + 1)));
      check_value("rr_grant", grant, 64'(k % 3));
      step();
      mem_resp_valid     = 1'b1;
      mem_resp_read_data = 32'hA000 + 32'(k);
      step();
      mem_resp_valid = 1'b0;
      if (k == 5) req_valid = 3'b000;
      settle();
      check_value("rr_resp", resp_v, oh);
      check_value("rr_data", rdata(k % 3), 64'(32'hA000 + 32'(k)));
    end

    // ch2 write under a 5-cycle downstream stall.
    step();
    mem_req_ready = 1'b0;
    set_req(2, 1'b1, 1'b1, 32'h8, 32'h55);
    settle();
    check_value("wr_ready", ready_v, 3'b100);
    step();
    req_valid = 3'b000;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_value("wr_stall_valid", mem_req_valid, 1'b1);
      check_value("wr_stall_addr", mem_req_address, 32'h8);
      check_value("wr_stall_wdata", mem_req_write_data, 32'h55);
      check_value("wr_stall_write", mem_req_write, 1'b1);
      check_value("wr_stall_grant", grant, 2'd2);
      step();
    end
    mem_req_ready = 1'b1;
    settle();
    check_value("wr_hs_valid", mem_req_valid, 1'b1);
    step();
    mem_req_ready = 1'b0;
    settle();
    check_value("wr_wait_resp", resp_v, 3'b000);
    step();
    mem_resp_valid     = 1'b1;
    mem_resp_read_data = 32'hFFFFFFFF;
    step();
    mem_resp_valid = 1'b0;
    settle();
    check_value("wr_resp", resp_v, 3'b100);
    check_value("wr_data_zero", ch2_resp_read_data, 32'h0);

    // Reset during WAIT_RESP, then a stray response.
    step();
    set_req(1, 1'b1, 1'b0, 32'h200, 32'h0);
    settle();
    check_value("mid_ready", ready_v, 3'b010);
    step();
    req_valid     = 3'b000;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    settle();
    check_value("mid_grant_busy", grant, 2'd1);
    clear = 1'b0;
    #1;
    check_value("mid_rst_grant", grant, 2'd3);
    check_value("mid_rst_mem_valid", mem_req_valid, 1'b0);
    step();
    clear              = 1'b1;
    mem_resp_valid     = 1'b1;
    mem_resp_read_data = 32'h1234;
    settle();
    check_value("stray_resp_a", resp_v, 3'b000);
    step();
    mem_resp_valid = 1'b0;
    settle();
    check_value("stray_resp_b", resp_v, 3'b000);
    check_value("stray_grant", grant, 2'd3);
    step();
    req_valid = 3'b111;
    settle();
    check_value("post_rst_ch0_wins", ready_v, 3'b001);
    step();
    req_valid     = 3'b000;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready      = 1'b0;
    mem_resp_valid     = 1'b1;
    mem_resp_read_data = 32'h5A5A;
    step();
    mem_resp_valid = 1'b0;
    settle();
    check_value("post_rst_resp", resp_v, 3'b001);

    // No response from memory: watchdog abort or indefinite wait.
    step();
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
    settle();
    check_value("wd_ready", ready_v, 3'b010);
    step();
    req_valid     = 3'b000;
    mem_req_ready = 1'b1;
    step();                                   // first WAIT_RESP cycle
    mem_req_ready = 1'b0;
`ifdef MEMORY_ARBITER_WATCHDOG_EN
    for (int i = 0; i < 4; i++) begin
      settle();
      check_value("wd_quiet_resp", resp_v, 3'b000);
      check_value("wd_quiet_timeout", timeout_error, 1'b0);
      step();
    end
    settle();
    check_value("wd_abort_resp", resp_v, 3'b010);
    check_value("wd_abort_data", ch1_resp_read_data, 32'h0);
    check_value("wd_abort_timeout", timeout_error, 1'b1);
    check_value("wd_abort_grant", grant, 2'd3);
    step();
    settle();
    check_value("wd_timeout_end", timeout_error, 1'b0);
`else
    for (int i = 0; i < 8; i++) begin
      settle();
      check_value("nowd_resp", resp_v, 3'b000);
      check_value("nowd_grant", grant, 2'd1);
      check_value("nowd_timeout", timeout_error, 1'b0);
      step();
    end
    mem_resp_valid     = 1'b1;
    mem_resp_read_data = 32'h77;
    step();
    mem_resp_valid = 1'b0;
    settle();
    check_value("nowd_late_resp", resp_v, 3'b010);
    check_value("nowd_late_data", ch1_resp_read_data, 32'h77);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
